// File: rtl/clock_divider_mc_if.sv
// clock_divider_mc_if
// Control/status bundle for the multi-channel clock divider.
//   scale     : packed per-channel scale values, channel c at [c*WIDTH +: WIDTH]
//   load      : one-cycle strobe capturing scale into masked channels' pending regs
//   load_mask : channel select for load
//   enable    : per-channel run enable (level)
//   clk_out   : divided clocks
//   tick      : one-cycle strobe at the first high cycle of each clk_out period
//   pending   : channel holds a loaded scale not yet applied
// master drives the controls, slave is the divider.
interface clock_divider_mc_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] scale;
    logic                      load;
    logic [CHANNELS-1:0]       load_mask;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       pending;

    modport master (
        output scale, load, load_mask, enable,
        input  clk_out, tick, pending
    );

    modport slave (
        input  scale, load, load_mask, enable,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/clock_divider_mc.sv
// clock_divider_mc
// Multi-channel programmable clock divider. Each channel divides clk_in by
// scale*MULT, with per-channel enable, odd divisors (high phase is the ceil
// half), a pending scale applied only at a period boundary, and a tick strobe
// marking the first high cycle of every output period.
//   clk_in : the only clock, rising-edge
//   rst    : asynchronous, active-high reset
//   bus    : clock_divider_mc_if slave (scale/load/load_mask/enable in,
//            clk_out/tick/pending out)
module clock_divider_mc #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int MULT     = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    clock_divider_mc_if.slave  bus
);

    localparam int CW = $clog2((2**WIDTH - 1) * MULT + 1);

    typedef enum logic [1:0] {
        MODE_DISABLED,
        MODE_BYPASS,
        MODE_DIVIDE
    } mode_e;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CW-1:0]    act_q, act_d;
        logic [CW-1:0]    pend_p_q, pend_p_d;
        logic             pend_v_q, pend_v_d;
        logic [CW-1:0]    count_q, count_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic [CW-1:0]    next_cnt;
        logic [CW-1:0]    high_len;
        logic             wrap;
        logic [WIDTH-1:0] scale_c;
        mode_e            mode;

        assign scale_c = bus.scale[c*WIDTH +: WIDTH];

        // Mode is decoded from registered period plus the live enable level.
        always_comb begin
            mode = MODE_DISABLED;
            if (bus.enable[c]) begin
                mode = (act_q <= CW'(1)) ? MODE_BYPASS : MODE_DIVIDE;
            end
        end

        always_comb begin
            act_d    = act_q;
            pend_p_d = pend_p_q;
            pend_v_d = pend_v_q;
            count_d  = count_q;
            out_d    = 1'b0;
            tick_d   = 1'b0;
            next_cnt = '0;
            high_len = '0;
            wrap     = 1'b0;

            case (mode)
                MODE_DIVIDE: begin
                    wrap     = (count_q == act_q - CW'(1));
                    next_cnt = wrap ? '0 : count_q + CW'(1);
                    if (wrap && pend_v_q) begin
                        act_d    = pend_p_q;
                        pend_v_d = 1'b0;
                    end
                    // High phase of the period now starting uses the new period.
                    high_len = act_d - (act_d >> 1);
                    count_d  = next_cnt;
                    out_d    = (next_cnt < high_len);
                    tick_d   = (next_cnt == '0);
                end
                default: begin
                    // DISABLED and BYPASS apply a pending value at once and park
                    // the counter at period-1, so the first DIVIDE edge wraps to
                    // 0 and opens a full period with a tick.
                    if (pend_v_q) begin
                        act_d    = pend_p_q;
                        pend_v_d = 1'b0;
                    end
                    count_d = (act_d == '0) ? '0 : act_d - CW'(1);
                end
            endcase

            // A load on the apply edge re-arms pending with the newer value.
            if (bus.load && bus.load_mask[c]) begin
                pend_p_d = CW'(scale_c) * CW'(MULT);
                pend_v_d = 1'b1;
            end
        end

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                act_q    <= '0;
                pend_p_q <= '0;
                pend_v_q <= 1'b0;
                count_q  <= '0;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                act_q    <= act_d;
                pend_p_q <= pend_p_d;
                pend_v_q <= pend_v_d;
                count_q  <= count_d;
                out_q    <= out_d;
                tick_q   <= tick_d;
            end
        end

        logic clk_sel;
        always_comb begin
            clk_sel = 1'b0;
            case (mode)
                MODE_BYPASS: clk_sel = clk_in;
                MODE_DIVIDE: clk_sel = out_q;
                default:     clk_sel = 1'b0;
            endcase
        end

        assign bus.clk_out[c] = clk_sel;
        assign bus.tick[c]    = tick_q;
        assign bus.pending[c] = pend_v_q;
    end

endmodule

// File: tb/tb_clock_divider_mc.sv
// tb_clock_divider_mc
// Drives two dividers (MULT=2 and MULT=1) with the same control stimulus and
// checks every output each cycle against a phase-position reference model.
module tb_clock_divider_mc;

    localparam int W  = 4;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst_s;
    logic [CH*W-1:0] scale_s;
    logic            load_s;
    logic [CH-1:0]   mask_s;
    logic [CH-1:0]   en_s;

    always #5 clk = ~clk;

    clock_divider_mc_if #(.WIDTH(W), .CHANNELS(CH)) if0 ();
    clock_divider_mc_if #(.WIDTH(W), .CHANNELS(CH)) if1 ();

    assign if0.scale = scale_s;  assign if1.scale = scale_s;
    assign if0.load = load_s;    assign if1.load = load_s;
    assign if0.load_mask = mask_s; assign if1.load_mask = mask_s;
    assign if0.enable = en_s;    assign if1.enable = en_s;

    clock_divider_mc #(.WIDTH(W), .CHANNELS(CH), .MULT(2)) dut0 (
        .clk_in(clk), .rst(rst_s), .bus(if0)
    );
    clock_divider_mc #(.WIDTH(W), .CHANNELS(CH), .MULT(1)) dut1 (
        .clk_in(clk), .rst(rst_s), .bus(if1)
    );

    logic [CH-1:0] clk_o [2];
    logic [CH-1:0] tick_o[2];
    logic [CH-1:0] pend_o[2];
    assign clk_o[0] = if0.clk_out;  assign clk_o[1] = if1.clk_out;
    assign tick_o[0] = if0.tick;    assign tick_o[1] = if1.tick;
    assign pend_o[0] = if0.pending; assign pend_o[1] = if1.pending;

    // Reference model: period length, cycles elapsed in the current period
    // (-1 = no period running yet), pending value/flag, expected out and tick.
    int act [2][CH];
    int pend[2][CH];
    int pos [2][CH];
    bit pv  [2][CH];
    bit mo  [2][CH];
    bit mt  [2][CH];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mult_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                act[d][c] = 0; pend[d][c] = 0; pos[d][c] = -1;
                pv[d][c] = 0;  mo[d][c] = 0;   mt[d][c] = 0;
            end
    endtask

    // One rising edge of clk_in with the currently applied inputs.
    task automatic model_step();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                mo[d][c] = 0;
                mt[d][c] = 0;
                if (!en_s[c] || act[d][c] <= 1) begin
                    if (pv[d][c]) begin
                        act[d][c] = pend[d][c];
                        pv[d][c]  = 0;
                    end
                    pos[d][c] = -1;
                end else begin
                    if (pos[d][c] == -1 || pos[d][c] == act[d][c] - 1) begin
                        if (pv[d][c]) begin
                            act[d][c] = pend[d][c];
                            pv[d][c]  = 0;
                        end
                        pos[d][c] = 0;
                        mt[d][c]  = 1;
                    end else begin
                        pos[d][c]++;
                    end
                    mo[d][c] = (pos[d][c] < (act[d][c] + 1) / 2);
                end
                if (load_s && mask_s[c]) begin
                    pend[d][c] = int'(scale_s[c*W +: W]) * mult_of(d);
                    pv[d][c]   = 1;
                end
            end
    endtask

    task automatic compare();
        logic exp_clk;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < CH; c++) begin
                if (!en_s[c])              exp_clk = 1'b0;
                else if (act[d][c] <= 1)   exp_clk = clk;
                else                       exp_clk = mo[d][c];
                check($sformatf("d%0d ch%0d clk_out", d, c), clk_o[d][c], exp_clk);
                check($sformatf("d%0d ch%0d tick", d, c), tick_o[d][c], mt[d][c]);
                check($sformatf("d%0d ch%0d pending", d, c), pend_o[d][c], pv[d][c]);
            end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_s) model_reset();
            else       model_step();
            #1;
            compare();
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [CH-1:0] m, input logic [CH*W-1:0] s);
        load_s = 1'b1; mask_s = m; scale_s = s;
        run(1);
        load_s = 1'b0;
    endtask

    initial begin
        rst_s = 1'b1; load_s = 1'b0; mask_s = '0; en_s = '0; scale_s = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        rst_s = 1'b0;
        run(2);

        // ch0 scale 3 (P=6 / P=3), ch1 scale 2 (P=4 / P=2), then run
        do_load(2'b11, {4'd2, 4'd3});
        en_s = 2'b11;
        run(20);

        // Rate change while running: scale 1 on ch0 only
        run(1);
        do_load(2'b01, {4'd7, 4'd1});
        run(12);

        // Scale 0 -> bypass after wrap, then disable ch0
        do_load(2'b01, {4'd0, 4'd0});
        run(14);
        en_s = 2'b10;
        run(4);

        // Back to P=6 on ch0, then load exactly on a wrap edge of dut0 ch0
        do_load(2'b01, {4'd0, 4'd3});
        en_s = 2'b11;
        run(8);
        do_load(2'b01, {4'd0, 4'd2});
        for (int i = 0; i < 20; i++) begin
            if (pos[0][0] == act[0][0] - 1) break;
            run(1);
        end
        check("wrap_reached", (pos[0][0] == act[0][0] - 1), 1);
        do_load(2'b01, {4'd0, 4'd5});
        check("pend_after_simul", pend_o[0][0], 1'b1);
        run(16);

        // Asynchronous reset in the middle of a period
        run(3);
        #2;
        rst_s = 1'b1;
        #1;
        model_reset();
        compare();
        check("rst_clk_out_low", clk_o[0], '0);
        @(negedge clk);
        run(2);
        rst_s = 1'b0;
        run(10);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            load_s  = ($urandom % 6) == 0;
            mask_s  = CH'($urandom);
            for (int c = 0; c < CH; c++)
                scale_s[c*W +: W] = W'($urandom_range(0, 6));
            if (($urandom % 40) == 0) en_s[$urandom % CH] = ~en_s[$urandom % CH];
            if (($urandom % 40) == 1) en_s = 2'b11;
            rst_s = ($urandom % 700) == 0;
            run(1);
        end
        rst_s = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
